// File: rtl/load_queue_ord_if.sv
// Load-queue bus: dispatch, execute-address, cache issue/response, commit and flush.
// The master side is the core/cache; the slave side is the load queue.
interface load_queue_ord_if #(
  parameter int LDQ_ENTRIES = 8,
  parameter int SDQ_ENTRIES = 8,
  parameter int ADDR_W      = 32
);
  localparam int IDX_W = $clog2(LDQ_ENTRIES);
  localparam int MRK_W = $clog2(SDQ_ENTRIES) + 1;

  logic              disp_vld;
  logic [MRK_W-1:0]  disp_sdq_marker;
  logic [IDX_W-1:0]  disp_ldq_idx;
  logic              disp_full;
  logic              exec_vld;
  logic [IDX_W-1:0]  exec_ldq_idx;
  logic [ADDR_W-1:0] exec_addr;
  logic              issue_vld;
  logic              issue_rdy;
  logic [IDX_W-1:0]  issue_idx;
  logic [ADDR_W-1:0] issue_addr;
  logic [MRK_W-1:0]  issue_sdq_marker;
  logic              resp_vld;
  logic [IDX_W-1:0]  resp_ldq_idx;
  logic              resp_replay;
  logic              commit_vld;
  logic              flush;
  logic [IDX_W:0]    ldq_count;

  modport master (
    output disp_vld, disp_sdq_marker, exec_vld, exec_ldq_idx, exec_addr,
           issue_rdy, resp_vld, resp_ldq_idx, resp_replay, commit_vld, flush,
    input  disp_ldq_idx, disp_full, issue_vld, issue_idx, issue_addr,
           issue_sdq_marker, ldq_count
  );

  modport slave (
    input  disp_vld, disp_sdq_marker, exec_vld, exec_ldq_idx, exec_addr,
           issue_rdy, resp_vld, resp_ldq_idx, resp_replay, commit_vld, flush,
    output disp_ldq_idx, disp_full, issue_vld, issue_idx, issue_addr,
           issue_sdq_marker, ldq_count
  );
endinterface

// File: rtl/load_queue_ord.sv
// Age-ordered load queue: in-order allocate/commit on a circular buffer,
// out-of-order address capture, oldest-ready issue to the cache with replay.
module load_queue_ord #(
  parameter int LDQ_ENTRIES = 8,
  parameter int SDQ_ENTRIES = 8,
  parameter int ADDR_W      = 32
) (
  input logic            clk,
  input logic            rst,
  load_queue_ord_if.slave bus
);
  localparam int IDX_W = $clog2(LDQ_ENTRIES);
  localparam int MRK_W = $clog2(SDQ_ENTRIES) + 1;

  typedef enum logic [2:0] {
    ST_FREE,
    ST_WAIT_ADDR,
    ST_READY,
    ST_INFLIGHT,
    ST_DONE
  } ent_state_t;

  ent_state_t        state_q [LDQ_ENTRIES];
  logic [ADDR_W-1:0] addr_q  [LDQ_ENTRIES];
  logic [MRK_W-1:0]  mrk_q   [LDQ_ENTRIES];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]    head_q;
  logic [IDX_W:0]    tail_q;
  logic [IDX_W-1:0]  head_idx;
  logic [IDX_W-1:0]  tail_idx;
  logic [IDX_W:0]    count;
  logic              full;
  logic              alloc;
  logic              commit_ok;
  logic              issue_fire;
  logic              exec_hit;
  logic              sel_vld;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  cand;

  assign head_idx   = head_q[IDX_W-1:0];
  assign tail_idx   = tail_q[IDX_W-1:0];
  assign count      = tail_q - head_q;
  assign full       = (count == (IDX_W+1)'(LDQ_ENTRIES));
  assign alloc      = bus.disp_vld && !full;
  assign commit_ok  = bus.commit_vld && (count != '0) && (state_q[head_idx] == ST_DONE);
  assign issue_fire = sel_vld && bus.issue_rdy;
  // Address is accepted while waiting for it or while still only READY.
  assign exec_hit   = bus.exec_vld &&
                      ((state_q[bus.exec_ldq_idx] == ST_WAIT_ADDR) ||
                       (state_q[bus.exec_ldq_idx] == ST_READY));

  // Oldest READY entry: walk from head toward tail, first hit wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = 0; i < LDQ_ENTRIES; i++) begin
      cand = head_idx + IDX_W'(i);
      if (!sel_vld && (state_q[cand] == ST_READY)) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign bus.disp_ldq_idx     = tail_idx;
  assign bus.disp_full        = full;
  assign bus.ldq_count        = count;
  assign bus.issue_vld        = sel_vld;
  assign bus.issue_idx        = sel_vld ? sel_idx : '0;
  assign bus.issue_addr       = sel_vld ? addr_q[sel_idx] : '0;
  assign bus.issue_sdq_marker = sel_vld ? mrk_q[sel_idx] : '0;

  // Per-entry state machines and pointers; flush shares the reset path.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < LDQ_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
      end
    end else begin
      if (alloc) begin
        state_q[tail_idx] <= ST_WAIT_ADDR;
        tail_q            <= tail_q + (IDX_W+1)'(1);
      end
      if (bus.exec_vld && (state_q[bus.exec_ldq_idx] == ST_WAIT_ADDR)) begin
        state_q[bus.exec_ldq_idx] <= ST_READY;
      end
      if (issue_fire) begin
        state_q[sel_idx] <= ST_INFLIGHT;
      end
      if (bus.resp_vld && (state_q[bus.resp_ldq_idx] == ST_INFLIGHT)) begin
        state_q[bus.resp_ldq_idx] <= bus.resp_replay ? ST_READY : ST_DONE;
      end
      if (commit_ok) begin
        state_q[head_idx] <= ST_FREE;
        head_q            <= head_q + (IDX_W+1)'(1);
      end
    end
  end

  // Entry payload: marker captured at allocate, address at execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LDQ_ENTRIES; i++) begin
        addr_q[i] <= '0;
        mrk_q[i]  <= '0;
      end
    end else if (!bus.flush) begin
      if (alloc) begin
        addr_q[tail_idx] <= '0;
        mrk_q[tail_idx]  <= bus.disp_sdq_marker;
      end
      if (exec_hit) begin
        addr_q[bus.exec_ldq_idx] <= bus.exec_addr;
      end
    end
  end
endmodule

// File: tb/tb_load_queue_ord.sv
// Directed bench for load_queue_ord: issue handshakes are checked against a
// scoreboard of hand-computed expectations; queue status is checked inline.
module tb_load_queue_ord;
  localparam int LDQ = 8;
  localparam int SDQ = 8;
  localparam int AW  = 32;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] addr;
    logic [3:0]  mrk;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  load_queue_ord_if #(.LDQ_ENTRIES(LDQ), .SDQ_ENTRIES(SDQ), .ADDR_W(AW)) bus ();

  load_queue_ord #(.LDQ_ENTRIES(LDQ), .SDQ_ENTRIES(SDQ), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One clock; pulse inputs drop right after the edge, issue_rdy is left as set.
  task automatic step();
    @(posedge clk);
    #1;
    bus.disp_vld    = 1'b0;
    bus.exec_vld    = 1'b0;
    bus.resp_vld    = 1'b0;
    bus.resp_replay = 1'b0;
    bus.commit_vld  = 1'b0;
    bus.flush       = 1'b0;
    rst             = 1'b0;
  endtask

  task automatic disp(input logic [3:0] mk);
    bus.disp_vld        = 1'b1;
    bus.disp_sdq_marker = mk;
  endtask

  task automatic exe(input logic [2:0] idx, input logic [31:0] addr);
    bus.exec_vld     = 1'b1;
    bus.exec_ldq_idx = idx;
    bus.exec_addr    = addr;
  endtask

  task automatic resp(input logic [2:0] idx, input logic rep);
    bus.resp_vld     = 1'b1;
    bus.resp_ldq_idx = idx;
    bus.resp_replay  = rep;
  endtask

  task automatic expect_issue(input logic [2:0] idx, input logic [31:0] addr, input logic [3:0] mk);
    exp_t e;
    e.idx  = idx;
    e.addr = addr;
    e.mrk  = mk;
    sb.push_back(e);
  endtask

  task automatic chk_offer(input string nm, input logic [2:0] idx, input logic [31:0] addr, input logic [3:0] mk);
    chk({nm, "_vld"},  32'(bus.issue_vld), 32'd1);
    chk({nm, "_idx"},  32'(bus.issue_idx), 32'(idx));
    chk({nm, "_addr"}, bus.issue_addr, addr);
    chk({nm, "_mrk"},  32'(bus.issue_sdq_marker), 32'(mk));
  endtask

  // Monitor: every accepted issue must match the next scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.issue_vld === 1'b1 && bus.issue_rdy === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected actual idx=%0d addr=%0h expected none",
                   bus.issue_idx, bus.issue_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("issue_hs", {bus.issue_idx, bus.issue_addr[24:0], bus.issue_sdq_marker},
              {e.idx, e.addr[24:0], e.mrk});
          chk("issue_hs_addr", bus.issue_addr, e.addr);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.disp_vld = 1'b0; bus.disp_sdq_marker = '0;
    bus.exec_vld = 1'b0; bus.exec_ldq_idx = '0; bus.exec_addr = '0;
    bus.issue_rdy = 1'b0;
    bus.resp_vld = 1'b0; bus.resp_ldq_idx = '0; bus.resp_replay = 1'b0;
    bus.commit_vld = 1'b0; bus.flush = 1'b0;
    @(posedge clk);
    rst = 1'b1;
    step();

    // Reset state
    chk("rst_count", 32'(bus.ldq_count), 32'd0);
    chk("rst_full", 32'(bus.disp_full), 32'd0);
    chk("rst_didx", 32'(bus.disp_ldq_idx), 32'd0);
    chk("rst_ivld", 32'(bus.issue_vld), 32'd0);

    // Three dispatches, exec out of order, oldest-ready selection
    for (int i = 0; i < 3; i++) begin
      chk("disp_idx", 32'(bus.disp_ldq_idx), 32'(i));
      disp(4'(i + 1));
      step();
    end
    chk("count3", 32'(bus.ldq_count), 32'd3);
    exe(3'd2, 32'h200); step();
    chk_offer("offer2", 3'd2, 32'h200, 4'd3);
    exe(3'd0, 32'h100); step();
    chk_offer("offer0", 3'd0, 32'h100, 4'd1);

    // Back-pressure holds the offer
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_idx", 32'(bus.issue_idx), 32'd0);
      chk("hold_vld", 32'(bus.issue_vld), 32'd1);
    end
    expect_issue(3'd0, 32'h100, 4'd1);
    bus.issue_rdy = 1'b1; step(); bus.issue_rdy = 1'b0;
    chk_offer("next_after_hs", 3'd2, 32'h200, 4'd3);

    // Replay re-competes by age ahead of younger READY entries
    disp(4'd4); exe(3'd1, 32'h180); step();
    chk("count4", 32'(bus.ldq_count), 32'd4);
    exe(3'd3, 32'h300); step();
    chk_offer("offer1", 3'd1, 32'h180, 4'd2);
    expect_issue(3'd1, 32'h180, 4'd2);
    bus.issue_rdy = 1'b1; step(); bus.issue_rdy = 1'b0;
    chk("offer_after1", 32'(bus.issue_idx), 32'd2);
    resp(3'd1, 1'b1); step();
    chk_offer("replay1", 3'd1, 32'h180, 4'd2);
    expect_issue(3'd1, 32'h180, 4'd2);
    expect_issue(3'd2, 32'h200, 4'd3);
    expect_issue(3'd3, 32'h300, 4'd4);
    bus.issue_rdy = 1'b1; step(); step(); step(); bus.issue_rdy = 1'b0;
    chk("all_inflight_vld", 32'(bus.issue_vld), 32'd0);
    resp(3'd0, 1'b0); step();
    resp(3'd1, 1'b0); step();
    bus.commit_vld = 1'b1; step();
    chk("commit_cnt3", 32'(bus.ldq_count), 32'd3);
    bus.commit_vld = 1'b1; step();
    chk("commit_cnt2", 32'(bus.ldq_count), 32'd2);
    bus.commit_vld = 1'b1; step();
    chk("commit_notdone", 32'(bus.ldq_count), 32'd2);

    // Fill to full, blocked dispatch, commit with dispatch in same cycle
    resp(3'd2, 1'b0); step();
    resp(3'd3, 1'b0); step();
    for (int i = 0; i < 6; i++) begin
      chk("fill_idx", 32'(bus.disp_ldq_idx), 32'((4 + i) % 8));
      disp(4'((4 + i) % 8 + 8));
      step();
    end
    chk("full_cnt", 32'(bus.ldq_count), 32'd8);
    chk("full_flag", 32'(bus.disp_full), 32'd1);
    disp(4'd0); step();
    chk("full_ignore_cnt", 32'(bus.ldq_count), 32'd8);
    chk("full_ignore_idx", 32'(bus.disp_ldq_idx), 32'd2);
    disp(4'd0); bus.commit_vld = 1'b1; step();
    chk("cmt_disp_cnt", 32'(bus.ldq_count), 32'd7);
    chk("cmt_disp_full", 32'(bus.disp_full), 32'd0);
    chk("cmt_disp_idx", 32'(bus.disp_ldq_idx), 32'd2);
    disp(4'd10); exe(3'd2, 32'hBAD); step();
    chk("wrap_cnt", 32'(bus.ldq_count), 32'd8);
    chk("same_cycle_exec", 32'(bus.issue_vld), 32'd0);
    exe(3'd3, 32'h999); step();
    chk("exec_done_ign", 32'(bus.issue_vld), 32'd0);
    exe(3'd5, 32'h500); step();
    chk_offer("exec5", 3'd5, 32'h500, 4'd13);
    exe(3'd5, 32'h550); step();
    chk_offer("exec5_ovw", 3'd5, 32'h550, 4'd13);

    // Flush with in-flight and ready entries plus concurrent traffic
    exe(3'd4, 32'h400); step();
    chk_offer("exec4", 3'd4, 32'h400, 4'd12);
    exe(3'd6, 32'h600); step();
    exe(3'd7, 32'h700); step();
    expect_issue(3'd4, 32'h400, 4'd12);
    expect_issue(3'd5, 32'h550, 4'd13);
    bus.issue_rdy = 1'b1; step(); step(); bus.issue_rdy = 1'b0;
    chk_offer("offer6", 3'd6, 32'h600, 4'd14);
    exe(3'd0, 32'h080); step();
    bus.flush = 1'b1; disp(4'd3); resp(3'd4, 1'b0); bus.commit_vld = 1'b1; step();
    chk("flush_cnt", 32'(bus.ldq_count), 32'd0);
    chk("flush_ivld", 32'(bus.issue_vld), 32'd0);
    chk("flush_iaddr", bus.issue_addr, 32'd0);
    chk("flush_didx", 32'(bus.disp_ldq_idx), 32'd0);
    chk("flush_full", 32'(bus.disp_full), 32'd0);
    resp(3'd3, 1'b0); step();
    chk("late_resp_cnt", 32'(bus.ldq_count), 32'd0);
    disp(4'd5); step();
    resp(3'd0, 1'b0); step();
    exe(3'd0, 32'h123); step();
    chk_offer("post_flush", 3'd0, 32'h123, 4'd5);
    resp(3'd0, 1'b0); step();
    chk_offer("resp_ready_ign", 3'd0, 32'h123, 4'd5);
    expect_issue(3'd0, 32'h123, 4'd5);
    bus.issue_rdy = 1'b1; step(); bus.issue_rdy = 1'b0;
    chk("pf_ivld", 32'(bus.issue_vld), 32'd0);
    chk("pf_cnt", 32'(bus.ldq_count), 32'd1);

    // Reset mid-traffic
    disp(4'd6); step();
    exe(3'd1, 32'h111); step();
    chk_offer("pre_rst", 3'd1, 32'h111, 4'd6);
    rst = 1'b1; disp(4'd7); step();
    chk("mrst_cnt", 32'(bus.ldq_count), 32'd0);
    chk("mrst_full", 32'(bus.disp_full), 32'd0);
    chk("mrst_didx", 32'(bus.disp_ldq_idx), 32'd0);
    chk("mrst_ivld", 32'(bus.issue_vld), 32'd0);
    chk("mrst_iidx", 32'(bus.issue_idx), 32'd0);
    chk("mrst_iaddr", bus.issue_addr, 32'd0);
    chk("mrst_imrk", 32'(bus.issue_sdq_marker), 32'd0);
    resp(3'd0, 1'b0); step();
    chk("mrst_late_resp", 32'(bus.ldq_count), 32'd0);
    bus.commit_vld = 1'b1; step();
    chk("empty_commit_cnt", 32'(bus.ldq_count), 32'd0);
    chk("empty_commit_idx", 32'(bus.disp_ldq_idx), 32'd0);
    disp(4'd7); step();
    exe(3'd0, 32'hABC); step();
    expect_issue(3'd0, 32'hABC, 4'd7);
    bus.issue_rdy = 1'b1; step(); bus.issue_rdy = 1'b0;
    resp(3'd0, 1'b0); step();
    bus.commit_vld = 1'b1; step();
    chk("final_cnt", 32'(bus.ldq_count), 32'd0);
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
